// File: rtl/tetris_board_renderer.sv
// -----------------------------------------------------------------------------
// tetris_board_renderer
//   Double-buffered Tetris board store plus a zero-latency pixel colouriser
//   for a VGA pipeline. The game writes cells into the back bank while the
//   front bank is displayed. Banks are exchanged only at the end of a visible
//   frame, so a frame never shows a half-updated board.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   x_i, y_i, xy_v_i        current pixel position and its visible qualifier
//   wr_v_i, wr_col_i,
//   wr_row_i, wr_code_i     single-cell write into the back bank
//   clear_i                 zero the whole back bank (overrides a write)
//   swap_req_i              level request to exchange banks at end of frame
//   swap_ack_o              one-cycle pulse after a swap has been performed
//   frame_tick_o            one-cycle pulse after the last visible pixel
//   r_o, g_o, b_o           combinational pixel colour
// -----------------------------------------------------------------------------
module tetris_board_renderer #(
    parameter int width_p      = 800,
    parameter int height_p     = 600,
    parameter int bit_depth_p  = 8,
    parameter int cell_px_p    = 16,
    parameter int board_cols_p = 10,
    parameter int board_rows_p = 20,
    parameter int origin_x_p   = 320,
    parameter int origin_y_p   = 140
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [$clog2(width_p)-1:0]      x_i,
    input  logic [$clog2(height_p)-1:0]     y_i,
    input  logic                            xy_v_i,
    input  logic                            wr_v_i,
    input  logic [$clog2(board_cols_p)-1:0] wr_col_i,
    input  logic [$clog2(board_rows_p)-1:0] wr_row_i,
    input  logic [2:0]                      wr_code_i,
    input  logic                            clear_i,
    input  logic                            swap_req_i,
    output logic                            swap_ack_o,
    output logic                            frame_tick_o,
    output logic [bit_depth_p-1:0]          r_o,
    output logic [bit_depth_p-1:0]          g_o,
    output logic [bit_depth_p-1:0]          b_o
);

    localparam int CELLS   = board_cols_p * board_rows_p;
    localparam int IW      = $clog2(CELLS);
    localparam int SH      = $clog2(cell_px_p);
    localparam int BOARD_W = board_cols_p * cell_px_p;
    localparam int BOARD_H = board_rows_p * cell_px_p;
    localparam int BD      = bit_depth_p;

    localparam logic [BD-1:0] FULL_C = {BD{1'b1}};
    localparam logic [BD-1:0] HALF_C = {1'b1, {(BD-1){1'b0}}};
    localparam logic [BD-1:0] ZERO_C = {BD{1'b0}};

    // Full-intensity palette entry for a cell code, packed {r, g, b}.
    function automatic logic [3*BD-1:0] palette(input logic [2:0] code);
        logic [3*BD-1:0] p;
        case (code)
            3'd0:    p = {ZERO_C, ZERO_C, ZERO_C};
            3'd1:    p = {ZERO_C, FULL_C, FULL_C};
            3'd2:    p = {FULL_C, FULL_C, ZERO_C};
            3'd3:    p = {HALF_C, ZERO_C, HALF_C};
            3'd4:    p = {ZERO_C, FULL_C, ZERO_C};
            3'd5:    p = {FULL_C, ZERO_C, ZERO_C};
            3'd6:    p = {ZERO_C, ZERO_C, FULL_C};
            3'd7:    p = {FULL_C, HALF_C, ZERO_C};
            default: p = {ZERO_C, ZERO_C, ZERO_C};
        endcase
        return p;
    endfunction

    logic [2:0]      banks_q [2][CELLS];
    logic [2:0]      banks_d [2][CELLS];
    logic            sel_q, sel_d;
    logic            swap_ack_q, swap_ack_d;
    logic            frame_tick_q, frame_tick_d;

    logic            back_s;
    logic            wr_ok_s;
    logic [IW-1:0]   wr_idx_s;
    logic            eof_s;

    int              bx_s, by_s, lx_s, ly_s;
    logic            interior_s, ring_s, edge_s;
    logic [IW-1:0]   rd_idx_s;
    logic [2:0]      code_s;
    logic [3*BD-1:0] pal_s;
    logic [3*BD-1:0] rgb_s;

    // Back-bank update, end-of-frame detection and bank-select next state.
    always_comb begin
        banks_d  = banks_q;
        back_s   = ~sel_q;
        wr_ok_s  = wr_v_i && (int'(wr_col_i) < board_cols_p)
                          && (int'(wr_row_i) < board_rows_p);
        wr_idx_s = IW'(int'(wr_row_i) * board_cols_p + int'(wr_col_i));
        // Writes always use the pre-swap back bank, even in the swap cycle.
        if (clear_i) begin
            for (int i = 0; i < CELLS; i++) begin
                banks_d[back_s][i] = 3'd0;
            end
        end else if (wr_ok_s) begin
            banks_d[back_s][wr_idx_s] = wr_code_i;
        end else begin
            banks_d[back_s][wr_idx_s] = banks_q[back_s][wr_idx_s];
        end
        eof_s = xy_v_i && (int'(x_i) == width_p - 1) && (int'(y_i) == height_p - 1);
        sel_d        = sel_q ^ (eof_s & swap_req_i);
        swap_ack_d   = eof_s & swap_req_i;
        frame_tick_d = eof_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < CELLS; i++) begin
                    banks_q[b][i] <= 3'd0;
                end
            end
            sel_q        <= 1'b0;
            swap_ack_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            banks_q      <= banks_d;
            sel_q        <= sel_d;
            swap_ack_q   <= swap_ack_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Pixel colour from the front bank; board offsets are signed so pixels
    // left of or above the origin land negative instead of wrapping inward.
    always_comb begin
        bx_s       = int'(x_i) - origin_x_p;
        by_s       = int'(y_i) - origin_y_p;
        interior_s = (bx_s >= 0) && (bx_s < BOARD_W) && (by_s >= 0) && (by_s < BOARD_H);
        ring_s     = (bx_s >= -2) && (bx_s < BOARD_W + 2)
                  && (by_s >= -2) && (by_s < BOARD_H + 2);
        lx_s       = bx_s & (cell_px_p - 1);
        ly_s       = by_s & (cell_px_p - 1);
        edge_s     = (lx_s == 0) || (lx_s == cell_px_p - 1)
                  || (ly_s == 0) || (ly_s == cell_px_p - 1);
        if (interior_s) begin
            rd_idx_s = IW'((by_s >>> SH) * board_cols_p + (bx_s >>> SH));
        end else begin
            rd_idx_s = {IW{1'b0}};
        end
        code_s = banks_q[sel_q][rd_idx_s];
        pal_s  = palette(code_s);
        if (!xy_v_i) begin
            rgb_s = {3*BD{1'b0}};
        end else if (interior_s) begin
            // Darkened outline on occupied cells gives each block a bevel.
            if ((code_s != 3'd0) && edge_s) begin
                rgb_s = {1'b0, pal_s[3*BD-1:2*BD+1],
                         1'b0, pal_s[2*BD-1:BD+1],
                         1'b0, pal_s[BD-1:1]};
            end else begin
                rgb_s = pal_s;
            end
        end else if (ring_s) begin
            rgb_s = {HALF_C, HALF_C, HALF_C};
        end else begin
            rgb_s = {3*BD{1'b0}};
        end
    end

    assign r_o          = rgb_s[3*BD-1:2*BD];
    assign g_o          = rgb_s[2*BD-1:BD];
    assign b_o          = rgb_s[BD-1:0];
    assign swap_ack_o   = swap_ack_q;
    assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_tetris_board_renderer.sv
// -----------------------------------------------------------------------------
// tb_tetris_board_renderer
//   Self-checking bench: directed scenarios plus randomized traffic compared
//   against a board model held as [bank][row][col] arrays and a palette table.
// -----------------------------------------------------------------------------
module tb_tetris_board_renderer;

    logic       clk = 1'b0;
    logic       reset_i;
    logic [9:0] x_i;
    logic [9:0] y_i;
    logic       xy_v_i;
    logic       wr_v_i;
    logic [3:0] wr_col_i;
    logic [4:0] wr_row_i;
    logic [2:0] wr_code_i;
    logic       clear_i;
    logic       swap_req_i;
    logic       swap_ack_o;
    logic       frame_tick_o;
    logic [7:0] r_o, g_o, b_o;

    int checks = 0;
    int errors = 0;

    logic [2:0]  mb [2][20][10];
    int          msel;
    logic [23:0] pal_tab [8];

    always #5 clk = ~clk;

    tetris_board_renderer dut (
        .clk_i(clk), .reset_i(reset_i),
        .x_i(x_i), .y_i(y_i), .xy_v_i(xy_v_i),
        .wr_v_i(wr_v_i), .wr_col_i(wr_col_i), .wr_row_i(wr_row_i),
        .wr_code_i(wr_code_i), .clear_i(clear_i), .swap_req_i(swap_req_i),
        .swap_ack_o(swap_ack_o), .frame_tick_o(frame_tick_o),
        .r_o(r_o), .g_o(g_o), .b_o(b_o)
    );

    function automatic logic [23:0] ref_rgb(int x, int y, logic v);
        int bx, by, col, row, lx, ly;
        logic [2:0]  code;
        logic [23:0] p;
        if (!v) return 24'h000000;
        bx = x - 320;
        by = y - 140;
        if (bx >= 0 && bx < 160 && by >= 0 && by < 320) begin
            col  = bx / 16;
            row  = by / 16;
            lx   = bx % 16;
            ly   = by % 16;
            code = mb[msel][row][col];
            p    = pal_tab[code];
            if (code != 3'd0 && (lx == 0 || lx == 15 || ly == 0 || ly == 15))
                p = {p[23:16] >> 1, p[15:8] >> 1, p[7:0] >> 1};
            return p;
        end
        if (bx >= -2 && bx < 162 && by >= -2 && by < 322) return 24'h808080;
        return 24'h000000;
    endfunction

    task automatic probe(input int x, input int y, input logic v, input string name);
        logic [23:0] exp;
        x_i    = x[9:0];
        y_i    = y[9:0];
        xy_v_i = v;
        #1;
        exp = ref_rgb(x, y, v);
        checks++;
        if ({r_o, g_o, b_o} !== exp) begin
            errors++;
            $display("FAIL %s x=%0d y=%0d v=%0b got=%h expected=%h", name, x, y, v,
                     {r_o, g_o, b_o}, exp);
        end
    endtask

    // One clock edge; eof places the end-of-frame pixel on the bus.
    task automatic edge_step(input bit eof, input string name);
        logic exp_tick, exp_ack;
        int   back;
        if (eof) begin x_i = 10'd799; y_i = 10'd599; xy_v_i = 1'b1; end
        else     begin x_i = 10'd0;   y_i = 10'd0;   xy_v_i = 1'b1; end
        if (reset_i) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 20; r++)
                    for (int c = 0; c < 10; c++) mb[b][r][c] = 3'd0;
            msel = 0; exp_tick = 1'b0; exp_ack = 1'b0;
        end else begin
            exp_tick = eof;
            exp_ack  = eof && swap_req_i;
            back     = 1 - msel;
            if (clear_i) begin
                for (int r = 0; r < 20; r++)
                    for (int c = 0; c < 10; c++) mb[back][r][c] = 3'd0;
            end else if (wr_v_i && wr_col_i < 4'd10 && wr_row_i < 5'd20) begin
                mb[back][wr_row_i][wr_col_i] = wr_code_i;
            end
            if (exp_ack) msel = 1 - msel;
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_tick_o !== exp_tick) begin
            errors++;
            $display("FAIL %s frame_tick got=%b expected=%b", name, frame_tick_o, exp_tick);
        end
        checks++;
        if (swap_ack_o !== exp_ack) begin
            errors++;
            $display("FAIL %s swap_ack got=%b expected=%b", name, swap_ack_o, exp_ack);
        end
        wr_v_i  = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic write_cell(input int c, input int r, input int code);
        wr_v_i    = 1'b1;
        wr_col_i  = c[3:0];
        wr_row_i  = r[4:0];
        wr_code_i = code[2:0];
    endtask

    task automatic sweep(input string name);
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) begin
                probe(320 + c * 16 + 8, 140 + r * 16 + 8, 1'b1, name);
                probe(320 + c * 16,     140 + r * 16 + 15, 1'b1, name);
            end
        probe(319, 300, 1'b1, name);
        probe(481, 300, 1'b1, name);
        probe(482, 300, 1'b1, name);
        probe(400, 137, 1'b1, name);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        edge_step(1'b0, "reset");
        edge_step(1'b0, "reset");
        reset_i = 1'b0;
        probe(330, 150, 1'b1, "reset_interior");
        probe(318, 150, 1'b1, "reset_ring");
        probe(100, 100, 1'b1, "reset_outside");
    endtask

    task automatic test_write_no_swap();
        write_cell(0, 0, 5);
        edge_step(1'b0, "wr_no_swap");
        swap_req_i = 1'b0;
        edge_step(1'b1, "eof_no_swap");
        edge_step(1'b0, "after_eof");
        probe(328, 148, 1'b1, "no_swap_front");
    endtask

    task automatic test_swap();
        swap_req_i = 1'b1;
        edge_step(1'b0, "swap_wait");
        probe(328, 148, 1'b1, "pre_swap_front");
        edge_step(1'b1, "swap_eof");
        swap_req_i = 1'b0;
        probe(328, 148, 1'b1, "swap_cell_center");
        probe(320, 148, 1'b1, "swap_cell_edge");
        probe(335, 155, 1'b1, "swap_cell_corner");
        edge_step(1'b0, "swap_ack_drop");
    endtask

    task automatic test_write_at_eof();
        write_cell(9, 19, 1);
        swap_req_i = 1'b1;
        edge_step(1'b1, "wr_at_eof");
        swap_req_i = 1'b0;
        probe(470, 450, 1'b1, "eof_write_visible");
        probe(479, 459, 1'b1, "eof_write_edge");
        write_cell(10, 0, 3);
        edge_step(1'b0, "oor_write");
        write_cell(0, 20, 3);
        edge_step(1'b0, "oor_row_write");
        swap_req_i = 1'b1;
        edge_step(1'b1, "oor_swap");
        swap_req_i = 1'b0;
        sweep("oor_sweep");
    endtask

    task automatic test_clear();
        write_cell(3, 4, 6);
        edge_step(1'b0, "clr_pre_wr");
        write_cell(5, 7, 2);
        clear_i = 1'b1;
        edge_step(1'b0, "clr_with_wr");
        swap_req_i = 1'b1;
        edge_step(1'b1, "clr_swap");
        swap_req_i = 1'b0;
        sweep("clr_sweep");
        for (int i = 0; i < 10; i++)
            probe($urandom_range(0, 798), $urandom_range(0, 598), 1'b0, "invisible");
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            wr_v_i     = ($urandom_range(0, 3) != 0);
            wr_col_i   = 4'($urandom_range(0, 15));
            wr_row_i   = 5'($urandom_range(0, 31));
            wr_code_i  = 3'($urandom_range(0, 7));
            clear_i    = ($urandom_range(0, 40) == 0);
            swap_req_i = ($urandom_range(0, 1) == 1);
            edge_step($urandom_range(0, 7) == 0, "rand_edge");
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 9) == 0)
                    probe($urandom_range(0, 798), $urandom_range(0, 598),
                          $urandom_range(0, 1) == 1, "rand_any");
                else
                    probe($urandom_range(310, 490), $urandom_range(130, 470),
                          $urandom_range(0, 7) != 0, "rand_board");
            end
        end
        swap_req_i = 1'b0;
    endtask

    task automatic test_reset_pending();
        write_cell(2, 2, 4);
        edge_step(1'b0, "rst_pre_wr");
        swap_req_i = 1'b1;
        edge_step(1'b0, "rst_pending");
        reset_i = 1'b1;
        edge_step(1'b0, "rst_mid");
        reset_i    = 1'b0;
        swap_req_i = 1'b0;
        edge_step(1'b1, "rst_eof");
        sweep("rst_sweep");
        swap_req_i = 1'b1;
        edge_step(1'b1, "rst_reassert");
        swap_req_i = 1'b0;
        sweep("rst_sweep2");
    endtask

    initial begin
        pal_tab[0] = 24'h000000; pal_tab[1] = 24'h00FFFF;
        pal_tab[2] = 24'hFFFF00; pal_tab[3] = 24'h800080;
        pal_tab[4] = 24'h00FF00; pal_tab[5] = 24'hFF0000;
        pal_tab[6] = 24'h0000FF; pal_tab[7] = 24'hFF8000;
        msel       = 0;
        reset_i    = 1'b1;
        x_i        = 10'd0;
        y_i        = 10'd0;
        xy_v_i     = 1'b0;
        wr_v_i     = 1'b0;
        wr_col_i   = 4'd0;
        wr_row_i   = 5'd0;
        wr_code_i  = 3'd0;
        clear_i    = 1'b0;
        swap_req_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_no_swap();
        test_swap();
        test_write_at_eof();
        test_clear();
        test_random();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tetris_board_renderer.md
TETRIS_BOARD_RENDERER -- requirements
Module: tetris_board_renderer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): width_p 800 visible width; height_p 600 visible height; bit_depth_p 8 bits per colour channel; cell_px_p 16 cell edge in pixels, power of two; board_cols_p 10 board columns; board_rows_p 20 board rows; origin_x_p 320 board left pixel; origin_y_p 140 board top pixel.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk_i  in  1  clock.
REQ-004 reset_i  in  1  synchronous active-high reset.
REQ-005 x_i  in  $clog2(width_p)  pixel x from the VGA controller.
REQ-006 y_i  in  $clog2(height_p)  pixel y from the VGA controller.
REQ-007 xy_v_i  in  1  x_i/y_i address a visible pixel.
REQ-008 wr_v_i  in  1  write one cell of the back bank.
REQ-009 wr_col_i  in  $clog2(board_cols_p)  write column.
REQ-010 wr_row_i  in  $clog2(board_rows_p)  write row.
REQ-011 wr_code_i  in  3  cell colour code (0 = empty).
REQ-012 clear_i  in  1  set every back-bank cell to 0.
REQ-013 swap_req_i  in  1  level request to exchange front/back banks.
REQ-014 swap_ack_o  out  1  one-cycle pulse: swap performed.
REQ-015 frame_tick_o  out  1  one-cycle pulse after last visible pixel of a frame.
REQ-016 r_o, g_o, b_o  out  bit_depth_p each  pixel colour to the VGA controller.

Function
REQ-017 Two banks of board_cols_p x board_rows_p 3-bit registers SHALL exist; bank-select bit sel names the front bank; the other is the back bank.
REQ-018 r_o/g_o/b_o SHALL be combinational from x_i, y_i, xy_v_i and front bank (zero-cycle latency); downstream samples them in the same cycle.
REQ-019 xy_v_i=0 SHALL force r_o=g_o=b_o=0.
REQ-020 bx=x_i-origin_x_p, by=y_i-origin_y_p; board interior: 0<=bx<board_cols_p*cell_px_p and 0<=by<board_rows_p*cell_px_p; col=bx>>log2(cell_px_p), row likewise, lx/ly=low log2(cell_px_p) bits.
REQ-021 Interior palette by code (8-bit values, wider/narrower depth: FF=all ones, 80=MSB only): 0 000000, 1 00FFFF, 2 FFFF00, 3 808080-free purple 800080, 4 00FF00, 5 FF0000, 6 0000FF, 7 FF8000.
REQ-022 Non-empty cell pixels with lx or ly equal to 0 or cell_px_p-1 SHALL output each palette channel shifted right by 1.
REQ-023 Pixels within 2 px outside the interior rectangle (frame ring) SHALL output 80/80/80; all other visible pixels SHALL output 0.
REQ-024 Comparisons SHALL be signed/wide enough that x_i<origin_x_p never aliases into the interior.
REQ-025 wr_v_i=1 with wr_col_i<board_cols_p and wr_row_i<board_rows_p SHALL write wr_code_i to the back bank at the next edge; out-of-range writes SHALL be ignored.
REQ-026 clear_i=1 SHALL zero the back bank at the next edge; a same-cycle write SHALL be dropped.
REQ-027 End-of-frame event E: xy_v_i=1, x_i=width_p-1, y_i=height_p-1; frame_tick_o SHALL be 1 in the cycle after E, else 0.
REQ-028 If swap_req_i=1 in the E cycle, sel SHALL toggle at that edge and swap_ack_o SHALL be 1 in the following cycle; otherwise no swap; requests are only serviced at E.
REQ-029 Write or clear in the E cycle with a swap SHALL target the pre-swap back bank (becoming front).
REQ-030 After a swap the new back bank SHALL hold the old front contents unchanged.
REQ-031 The front bank SHALL never change except via swap, so no tearing within a frame.

Reset
REQ-032 reset_i SHALL zero both banks, sel=0, swap_ack_o=0, frame_tick_o=0; reset mid-frame or with swap pending SHALL discard the request; colour outputs follow REQ-018 from reset state (visible pixels black or frame-ring grey).

Verification
REQ-033 Reset, xy_v_i=1, x=330,y=150 -> rgb=000000; x=318,y=150 -> 808080; x=100,y=100 -> 000000.
REQ-034 Write col0,row0 code5, no swap, E with swap_req=0 -> x=328,y=148 still 000000; frame_tick_o pulses, swap_ack_o=0.
REQ-035 Hold swap_req=1 through E -> swap_ack_o=1 one cycle after E; x=328,y=148 -> FF0000; x=320,y=148 -> 7F0000.
REQ-036 Write col9,row19 code1 at E cycle with swap -> x=470,y=450 -> 00FFFF next frame; out-of-range write col10 -> no bank change.
REQ-037 clear_i and wr_v_i same cycle then swap -> all cells 0; xy_v_i=0 anywhere -> rgb 0.
REQ-038 Assert reset_i with swap_req=1 mid-frame -> no swap_ack_o at following E unless request reasserted; banks zero.
